// File: rtl/btn_cond_defs.sv
// ============================================================
// btn_cond_defs: shared repeat-FSM encodings and width helpers
// Revision 1.0
// ============================================================
`default_nettype none

package btn_cond_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Smallest r with 2**r >= value; used as clog2(limit+1) so results are never zero.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_channel.sv
// ============================================================
// btn_channel: one-bit synchroniser, tick debouncer and auto-repeat FSM
// Revision 1.0
// ============================================================
`default_nettype none

module btn_channel
  import btn_cond_defs::*;
#(
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100,
  parameter bit ACTIVE_LOW         = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  input  logic i_repeat_en,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_step
);

  localparam int DB_W = clog2(DEBOUNCE_TICKS + 1);
  localparam int RC_W = clog2(max2(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS) + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RC_W-1:0] RR_LAST = RC_W'(REPEAT_RATE_TICKS - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            step_q, step_d;
  rep_state_e      state_q, state_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;

  // Debounce: any cycle agreeing with the accepted level restarts the count.
  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (cnt_q == DB_LAST) begin
        level_d   = sync2_q;
        cnt_d     = '0;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    step_d  = 1'b0;
    if (release_d) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_d) begin
            step_d  = 1'b1;
            state_d = ST_HOLD;
            rcnt_d  = '0;
          end
        end
        ST_HOLD: begin
          if (i_repeat_en && i_tick) begin
            if (rcnt_q == RD_LAST) begin
              step_d  = 1'b1;
              state_d = ST_REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RC_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          // Dropping the enable re-arms the full initial delay.
          if (!i_repeat_en) begin
            state_d = ST_HOLD;
            rcnt_d  = '0;
          end else if (i_tick) begin
            if (rcnt_q == RR_LAST) begin
              step_d = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RC_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
    end else begin
      sync1_q   <= i_btn ^ ACTIVE_LOW;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_step    = step_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================
// button_conditioner: N-channel push-button front-end with shared debounce tick
// Revision 1.0
// ============================================================
`default_nettype none

module button_conditioner
  import btn_cond_defs::*;
#(
  parameter int N_BTN              = 6,
  parameter int CYCLES_PER_TICK    = 12000,
  parameter int DEBOUNCE_TICKS     = 20,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100,
  parameter bit ACTIVE_LOW         = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  input  logic [N_BTN-1:0] i_repeat_en,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_step,
  output logic             o_tick
);

  localparam int PS_W = clog2(CYCLES_PER_TICK + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CYCLES_PER_TICK - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  // With CYCLES_PER_TICK=1 the count sits at zero and the tick stays high.
  always_comb begin
    ps_d = ps_q + PS_W'(1);
    if (ps_q == PS_LAST) ps_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ps_q <= '0;
    else         ps_q <= ps_d;
  end

  assign tick   = (ps_q == PS_LAST);
  assign o_tick = tick;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_TICKS    (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS),
      .ACTIVE_LOW        (ACTIVE_LOW)
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_btn      (i_btn[g]),
      .i_repeat_en(i_repeat_en[g]),
      .i_tick     (tick),
      .o_level    (o_level[g]),
      .o_press    (o_press[g]),
      .o_release  (o_release[g]),
      .o_step     (o_step[g])
    );
  end

endmodule

`default_nettype wire
